// File: rtl/d2x4_decoder.sv
// Registered 2-to-4 line decoder with enable and per-line saturating hit counters.
//
// Ports:
//   clk      - single clock, all state updates on the rising edge
//   rst_n    - synchronous active-low reset, overrides every other input
//   en       - decode enable
//   A, B     - select index {A,B}, A is the MSB
//   cnt_clr  - synchronous clear of all hit counters (wins over an increment)
//   cnt_sel  - selects which line's counter drives hit_cnt
//   D        - registered one-hot decode (inverted when OUT_ACTIVE_LOW)
//   valid    - registered en: D holds a decoded value
//   chg      - one-cycle pulse when the decoded index changed or decode restarted
//   idx      - registered index of the asserted line
//   hit_cnt  - counter of line cnt_sel, combinational mux of the counter registers
module d2x4_decoder #(
  parameter bit          OUT_ACTIVE_LOW = 1'b0,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             A,
  input  logic             B,
  input  logic             cnt_clr,
  input  logic [1:0]       cnt_sel,
  output logic [3:0]       D,
  output logic             valid,
  output logic             chg,
  output logic [1:0]       idx,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam int unsigned N_LINES = 4;
  localparam logic [3:0] D_IDLE = OUT_ACTIVE_LOW ? 4'b1111 : 4'b0000;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0] sel_c;
  logic [3:0] onehot_c;
  logic [3:0] d_next_c;
  logic [N_LINES-1:0][CNT_W-1:0] cnt_q;

  // Decode the sampled index and apply output polarity.
  assign sel_c    = {A, B};
  assign onehot_c = 4'(1) << sel_c;
  assign d_next_c = OUT_ACTIVE_LOW ? ~onehot_c : onehot_c;

  // Decode path: D, valid, change pulse and index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      D     <= D_IDLE;
      valid <= 1'b0;
      chg   <= 1'b0;
      idx   <= 2'd0;
    end else if (en) begin
      D     <= d_next_c;
      valid <= 1'b1;
      // A restart after reset/disable counts as a change even if the index matches.
      chg   <= !valid || (sel_c != idx);
      idx   <= sel_c;
    end else begin
      D     <= D_IDLE;
      valid <= 1'b0;
      chg   <= 1'b0;
    end
  end

  // Per-line saturating hit counters; clear drops the same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q[sel_c] != CNT_MAX)) begin
      cnt_q[sel_c] <= cnt_q[sel_c] + CNT_W'(1);
    end
  end

  assign hit_cnt = cnt_q[cnt_sel];

endmodule

// File: tb/tb_d2x4_decoder.sv
// Scoreboard bench for d2x4_decoder: three instances share stimulus
// (default, CNT_W=2 for saturation, OUT_ACTIVE_LOW=1 for polarity).
module tb_d2x4_decoder;

  typedef struct packed {
    logic [3:0] d;
    logic       v;
    logic       c;
    logic [1:0] idx;
    logic [7:0] cnt;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       a;
  logic       b;
  logic       cnt_clr;
  logic [1:0] cnt_sel;

  logic [3:0] d_m, d_s, d_l;
  logic       v_m, v_s, v_l;
  logic       c_m, c_s, c_l;
  logic [1:0] i_m, i_s, i_l;
  logic [7:0] h_m, h_l;
  logic [1:0] h_s;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   stim_done = 1'b0;

  d2x4_decoder #(.OUT_ACTIVE_LOW(1'b0), .CNT_W(8)) dut_main (
    .clk(clk), .rst_n(rst_n), .en(en), .A(a), .B(b), .cnt_clr(cnt_clr),
    .cnt_sel(cnt_sel), .D(d_m), .valid(v_m), .chg(c_m), .idx(i_m), .hit_cnt(h_m));

  d2x4_decoder #(.OUT_ACTIVE_LOW(1'b0), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .A(a), .B(b), .cnt_clr(cnt_clr),
    .cnt_sel(cnt_sel), .D(d_s), .valid(v_s), .chg(c_s), .idx(i_s), .hit_cnt(h_s));

  d2x4_decoder #(.OUT_ACTIVE_LOW(1'b1), .CNT_W(8)) dut_low (
    .clk(clk), .rst_n(rst_n), .en(en), .A(a), .B(b), .cnt_clr(cnt_clr),
    .cnt_sel(cnt_sel), .D(d_l), .valid(v_l), .chg(c_l), .idx(i_l), .hit_cnt(h_l));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and queue the hand-computed response after the next edge.
  task automatic step(input logic r, input logic e, input logic [1:0] ab, input logic clr,
                      input logic [1:0] sel, input logic [3:0] ed, input logic ev,
                      input logic ec, input logic [1:0] ei, input logic [7:0] ecnt);
    exp_t x;
    @(posedge clk);
    #2;
    rst_n   = r;
    en      = e;
    {a, b}  = ab;
    cnt_clr = clr;
    cnt_sel = sel;
    x.d = ed; x.v = ev; x.c = ec; x.idx = ei; x.cnt = ecnt;
    q.push_back(x);
  endtask

  // Monitor: one expected entry per cycle, checked just after the sampling edge.
  initial begin
    exp_t x;
    logic [7:0] sat;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        sat = (x.cnt > 8'd3) ? 8'd3 : x.cnt;
        check("main_D",     {4'd0, d_m},        {4'd0, x.d});
        check("main_valid", {7'd0, v_m},        {7'd0, x.v});
        check("main_chg",   {7'd0, c_m},        {7'd0, x.c});
        check("main_idx",   {6'd0, i_m},        {6'd0, x.idx});
        check("main_hit",   h_m,                x.cnt);
        check("sat_hit",    {6'd0, h_s},        sat);
        check("sat_chg",    {7'd0, c_s},        {7'd0, x.c});
        check("low_D",      {4'd0, d_l},        {4'd0, ~x.d});
        check("low_valid",  {7'd0, v_l},        {7'd0, x.v});
      end
    end
  end

  initial begin
    int wait_cycles;
    rst_n = 1'b0; en = 1'b1; a = 1'b1; b = 1'b1; cnt_clr = 1'b0; cnt_sel = 2'd3;
    //    rst en  ab  clr sel  D        v  c  idx  cnt
    // reset held two cycles with en=1, {A,B}=11
    step(0, 1, 2'd3, 0, 2'd3, 4'b0000, 0, 0, 2'd0, 8'd0);
    step(0, 1, 2'd3, 0, 2'd3, 4'b0000, 0, 0, 2'd0, 8'd0);
    // sweep all four indices
    step(1, 1, 2'd0, 0, 2'd0, 4'b0001, 1, 1, 2'd0, 8'd1);
    step(1, 1, 2'd1, 0, 2'd1, 4'b0010, 1, 1, 2'd1, 8'd1);
    step(1, 1, 2'd2, 0, 2'd2, 4'b0100, 1, 1, 2'd2, 8'd1);
    step(1, 1, 2'd3, 0, 2'd3, 4'b1000, 1, 1, 2'd3, 8'd1);
    // clear with a simultaneous increment: count dropped, decode unaffected
    step(1, 1, 2'd2, 1, 2'd2, 4'b0100, 1, 1, 2'd2, 8'd0);
    // hold index 2 for 5 cycles
    step(1, 1, 2'd2, 0, 2'd2, 4'b0100, 1, 0, 2'd2, 8'd1);
    step(1, 1, 2'd2, 0, 2'd2, 4'b0100, 1, 0, 2'd2, 8'd2);
    step(1, 1, 2'd2, 0, 2'd2, 4'b0100, 1, 0, 2'd2, 8'd3);
    step(1, 1, 2'd2, 0, 2'd2, 4'b0100, 1, 0, 2'd2, 8'd4);
    step(1, 1, 2'd2, 0, 2'd2, 4'b0100, 1, 0, 2'd2, 8'd5);
    // disable: outputs idle, idx and counters frozen
    step(1, 0, 2'd2, 0, 2'd2, 4'b0000, 0, 0, 2'd2, 8'd5);
    step(1, 0, 2'd1, 0, 2'd2, 4'b0000, 0, 0, 2'd2, 8'd5);
    // re-enable with the same index gives a change pulse
    step(1, 1, 2'd2, 0, 2'd2, 4'b0100, 1, 1, 2'd2, 8'd6);
    // hold index 3 for 6 cycles: CNT_W=2 instance saturates at 3
    step(1, 1, 2'd3, 0, 2'd3, 4'b1000, 1, 1, 2'd3, 8'd1);
    step(1, 1, 2'd3, 0, 2'd3, 4'b1000, 1, 0, 2'd3, 8'd2);
    step(1, 1, 2'd3, 0, 2'd3, 4'b1000, 1, 0, 2'd3, 8'd3);
    step(1, 1, 2'd3, 0, 2'd3, 4'b1000, 1, 0, 2'd3, 8'd4);
    step(1, 1, 2'd3, 0, 2'd3, 4'b1000, 1, 0, 2'd3, 8'd5);
    step(1, 1, 2'd3, 0, 2'd3, 4'b1000, 1, 0, 2'd3, 8'd6);
    // clear while enabled on a saturated line
    step(1, 1, 2'd3, 1, 2'd3, 4'b1000, 1, 0, 2'd3, 8'd0);
    step(1, 1, 2'd3, 0, 2'd3, 4'b1000, 1, 0, 2'd3, 8'd1);
    // counter select independent of decoded line
    step(1, 1, 2'd1, 0, 2'd0, 4'b0010, 1, 1, 2'd1, 8'd0);
    step(1, 1, 2'd1, 0, 2'd1, 4'b0010, 1, 0, 2'd1, 8'd2);
    step(1, 1, 2'd0, 0, 2'd2, 4'b0001, 1, 1, 2'd0, 8'd0);
    // mid-run reset overrides en
    step(0, 1, 2'd3, 0, 2'd1, 4'b0000, 0, 0, 2'd0, 8'd0);
    // first decode after reset, index 01 (active-low instance shows 1101)
    step(1, 1, 2'd1, 0, 2'd1, 4'b0010, 1, 1, 2'd1, 8'd1);
    step(1, 1, 2'd0, 0, 2'd1, 4'b0001, 1, 1, 2'd0, 8'd1);
    stim_done = 1'b1;

    wait_cycles = 0;
    while (q.size() != 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #3;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
